param_vend_ctrl: RTL and testbench
==================================

PARAM_VEND_CTRL -- requirements
Module: param_vend_ctrl

Interface
REQ-001 Parameter PRICE_Q, default 3: item price in quarters; 1 <= PRICE_Q <= MAX_CREDIT_Q.
REQ-002 Parameter MAX_CREDIT_Q, default 7: credit ceiling in quarters; MAX_CREDIT_Q < 2**CW.
REQ-003 Parameter CW, default 3: credit register width.
REQ-004 Parameter STOCK, default 8: item count loaded at reset/restock; SW = $clog2(STOCK+1).
REQ-005 CLK  in  1  single system clock; all state changes on rising edge.
REQ-006 RES  in  1  reset, synchronous, active-high.
REQ-007 quarter_in / halfDollar_in / dollar_in  in  1 each  debounced one-cycle coin pulses worth 1/2/4 quarters.
REQ-008 restock  in  1  one-cycle pulse reloading stock count.
REQ-009 cancel  in  1  refund request (present only with PVC_CANCEL_EN).
REQ-010 guffin  out  1  item dispense pulse.
REQ-011 quarter_out / halfDollar_out  out  1 each  change-coin pulses.
REQ-012 coin_reject  out  1  one-cycle pulse: the coin presented on the previous edge was not credited.
REQ-013 sold_out  out  1  high while stock count == 0.
REQ-014 credit  out  CW  current credit in quarters (registered).
REQ-015 state  out  2  encoded state: IDLE=0, COLLECT=1, VEND=2, CHANGE=3.

Function
REQ-016 States: IDLE (credit 0), COLLECT (0 < credit < PRICE_Q), VEND, CHANGE.
REQ-017 Coins are sampled only in IDLE/COLLECT; a coin pulse arriving in VEND or CHANGE is rejected.
REQ-018 Coins are rejected, with credit unchanged, when more than one coin input is high in the same cycle.
REQ-019 Coins are rejected when sold_out = 1.
REQ-020 Coins are rejected when credit + value > MAX_CREDIT_Q (no wrap, no saturation).
REQ-021 On acceptance, credit takes credit + value on the same edge. The next state is VEND if the new credit >= PRICE_Q, otherwise COLLECT.
REQ-022 coin_reject is asserted for exactly one cycle, in the cycle after a rejected coin.
REQ-023 VEND lasts exactly one cycle: guffin = 1 and credit shows the pre-vend value.
REQ-024 On leaving VEND: credit -= PRICE_Q and stock -= 1. The next state is CHANGE if the remainder > 0, otherwise IDLE.
REQ-025 In each CHANGE cycle, if credit >= 2: halfDollar_out = 1 and credit -= 2.
REQ-026 In each CHANGE cycle, if credit = 1: quarter_out = 1 and credit -= 1.
REQ-027 CHANGE goes to IDLE on the edge where credit reaches 0. At most one change output is high per cycle.
REQ-028 guffin, quarter_out and halfDollar_out are Moore decodes of registered state/credit, with no input-to-output combinational path.
REQ-029 restock is honoured only in IDLE: stock <= STOCK, and sold_out clears on the next edge. It is ignored in other states.
REQ-030 Stock never decrements below 0. VEND is unreachable while sold_out = 1.

Reset
REQ-031 While RES is high at an edge, outputs take these values: state = IDLE, credit = 0, stock = STOCK, sold_out = (STOCK == 0), and all pulse outputs = 0.
REQ-032 Reset mid-operation, including in VEND or CHANGE, discards credit and owed change without emitting further pulses. RES has priority over all inputs.

Configuration
REQ-033 With PVC_CANCEL_EN defined, the cancel port exists.
REQ-034 With PVC_CANCEL_EN defined, cancel in COLLECT moves the block to CHANGE on that edge and refunds the full credit per REQ-025..027.
REQ-035 With PVC_CANCEL_EN defined, cancel in IDLE, VEND or CHANGE is ignored.
REQ-036 With PVC_CANCEL_EN defined, cancel together with a coin in the same cycle gives priority to cancel, and the coin is rejected.
REQ-037 Without PVC_CANCEL_EN, the cancel port and logic are absent, and credit in COLLECT persists until a vend.

Verification
REQ-038 Defaults, dollar_in pulse: credit 4 and VEND (guffin 1 cycle) -> credit 1 and CHANGE (quarter_out 1 cycle) -> IDLE, credit 0.
REQ-039 Defaults, halfDollar_in then dollar_in: credit 2 -> 6 -> VEND -> credit 3 -> halfDollar_out -> credit 1 -> quarter_out -> IDLE.
REQ-040 PRICE_Q=8, MAX_CREDIT_Q=9, CW=4:
- halfDollar_in, then dollar_in: credit reaches 6.
- dollar_in: rejected, coin_reject pulses next cycle, credit stays 6.
REQ-041 STOCK=1: first vend completes. Afterwards sold_out = 1 and any coin is rejected. restock in IDLE clears sold_out next cycle.
REQ-042 quarter_in and dollar_in high together -> coin_reject, credit 0. RES asserted during CHANGE with credit 3 -> next cycle IDLE, credit 0, no change pulses.
REQ-043 PVC_CANCEL_EN defined, defaults: halfDollar_in, then cancel -> CHANGE, halfDollar_out once -> IDLE, guffin never asserted.

Source files
------------

// File: rtl/param_vend_ctrl_if.sv
// Coin, dispense and status signals of the vending controller.
// Optional refund port exists only when PVC_CANCEL_EN is defined.
interface param_vend_ctrl_if #(
  parameter int unsigned CW = 3
);
`ifdef PVC_CANCEL_EN
  logic          cancel;
`endif
  logic          quarter_in;
  logic          halfDollar_in;
  logic          dollar_in;
  logic          restock;
  logic          guffin;
  logic          quarter_out;
  logic          halfDollar_out;
  logic          coin_reject;
  logic          sold_out;
  logic [CW-1:0] credit;
  logic [1:0]    state;

  modport master (
`ifdef PVC_CANCEL_EN
    output cancel,
`endif
    output quarter_in, halfDollar_in, dollar_in, restock,
    input  guffin, quarter_out, halfDollar_out, coin_reject, sold_out, credit, state
  );

  modport slave (
`ifdef PVC_CANCEL_EN
    input  cancel,
`endif
    input  quarter_in, halfDollar_in, dollar_in, restock,
    output guffin, quarter_out, halfDollar_out, coin_reject, sold_out, credit, state
  );
endinterface

// File: rtl/param_vend_ctrl.sv
// Parameterised coin-operated vending controller with change return.
// Define PVC_CANCEL_EN to enable refund of partial credit via the cancel input.
module param_vend_ctrl #(
  parameter int unsigned PRICE_Q      = 3,
  parameter int unsigned MAX_CREDIT_Q = 7,
  parameter int unsigned CW           = 3,
  parameter int unsigned STOCK        = 8
) (
  input  logic            CLK,
  input  logic            RES,
  param_vend_ctrl_if.slave bus
);
  localparam int unsigned SW = (STOCK > 0) ? $clog2(STOCK + 1) : 1;
  // Sum width leaves headroom for a dollar on top of any credit value.
  localparam int unsigned AW = CW + 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [SW-1:0] stock_q, stock_d;
  logic          coin_reject_q, coin_reject_d;
  logic          cancel_req;
  logic          sold_out;
  logic          coin_any, coin_multi;
  logic [AW-1:0] coin_val, sum_w;

`ifdef PVC_CANCEL_EN
  assign cancel_req = bus.cancel;
`else
  assign cancel_req = 1'b0;
`endif

  assign sold_out = (stock_q == '0);

  always_comb begin
    coin_any   = bus.quarter_in | bus.halfDollar_in | bus.dollar_in;
    coin_multi = (bus.quarter_in & bus.halfDollar_in) |
                 (bus.quarter_in & bus.dollar_in) |
                 (bus.halfDollar_in & bus.dollar_in);
    coin_val   = bus.dollar_in     ? AW'(4) :
                 bus.halfDollar_in ? AW'(2) :
                 bus.quarter_in    ? AW'(1) : '0;
    sum_w      = AW'(credit_q) + coin_val;

    state_d       = state_q;
    credit_d      = credit_q;
    stock_d       = stock_q;
    coin_reject_d = 1'b0;

    case (state_q)
      IDLE, COLLECT: begin
        if (state_q == COLLECT && cancel_req) begin
          // Refund wins over a simultaneous coin; the coin is bounced.
          state_d       = CHANGE;
          coin_reject_d = coin_any;
        end else if (coin_any) begin
          if (coin_multi || sold_out || (sum_w > AW'(MAX_CREDIT_Q))) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = CW'(sum_w);
            state_d  = (sum_w >= AW'(PRICE_Q)) ? VEND : COLLECT;
          end
        end
        if (state_q == IDLE && bus.restock) begin
          stock_d = SW'(STOCK);
        end
      end
      VEND: begin
        coin_reject_d = coin_any;
        credit_d      = credit_q - CW'(PRICE_Q);
        if (stock_q != '0) begin
          stock_d = stock_q - SW'(1);
        end
        state_d = (credit_q > CW'(PRICE_Q)) ? CHANGE : IDLE;
      end
      CHANGE: begin
        coin_reject_d = coin_any;
        if (credit_q >= CW'(2)) begin
          credit_d = credit_q - CW'(2);
        end else if (credit_q != '0) begin
          credit_d = credit_q - CW'(1);
        end
        state_d = (credit_d == '0) ? IDLE : CHANGE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      stock_q       <= SW'(STOCK);
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      stock_q       <= stock_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  // Dispense and change pulses decode registered state only.
  assign bus.guffin         = (state_q == VEND);
  assign bus.halfDollar_out = (state_q == CHANGE) && (credit_q >= CW'(2));
  assign bus.quarter_out    = (state_q == CHANGE) && (credit_q == CW'(1));
  assign bus.coin_reject    = coin_reject_q;
  assign bus.sold_out       = sold_out;
  assign bus.credit         = credit_q;
  assign bus.state          = state_q;
endmodule

// File: tb/tb_param_vend_ctrl.sv
// Scoreboard bench for param_vend_ctrl: three parameterisations, expected
// output pulses queued by stimulus and matched by a negedge monitor.
module tb_param_vend_ctrl;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst0, rst1, rst2;

  param_vend_ctrl_if #(.CW(3)) if0 ();
  param_vend_ctrl_if #(.CW(4)) if1 ();
  param_vend_ctrl_if #(.CW(3)) if2 ();

  param_vend_ctrl dut0 (.CLK(CLK), .RES(rst0), .bus(if0.slave));
  param_vend_ctrl #(.PRICE_Q(8), .MAX_CREDIT_Q(9), .CW(4)) dut1 (
    .CLK(CLK), .RES(rst1), .bus(if1.slave));
  param_vend_ctrl #(.STOCK(1)) dut2 (.CLK(CLK), .RES(rst2), .bus(if2.slave));

  localparam logic [3:0] K_G = 4'b1000;
  localparam logic [3:0] K_H = 4'b0100;
  localparam logic [3:0] K_Q = 4'b0010;
  localparam logic [3:0] K_R = 4'b0001;

  typedef struct {
    int         id;
    logic [3:0] kind;
    int         cr;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic expect_ev(input int id, input logic [3:0] kind, input int cr);
    ev_t e;
    e.id = id; e.kind = kind; e.cr = cr;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input int id, input logic q, input logic h, input logic d, input logic r);
    case (id)
      0: begin if0.quarter_in = q; if0.halfDollar_in = h; if0.dollar_in = d; if0.restock = r; end
      1: begin if1.quarter_in = q; if1.halfDollar_in = h; if1.dollar_in = d; if1.restock = r; end
      default: begin if2.quarter_in = q; if2.halfDollar_in = h; if2.dollar_in = d; if2.restock = r; end
    endcase
  endtask

  task automatic drive(input int id, input logic q, input logic h, input logic d, input logic r);
    set_in(id, q, h, d, r);
    tick();
    set_in(id, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic ev_t observe(input int id);
    ev_t o;
    o.id = id;
    case (id)
      0: begin
        o.kind = {if0.guffin, if0.halfDollar_out, if0.quarter_out, if0.coin_reject};
        o.cr   = int'(if0.credit);
      end
      1: begin
        o.kind = {if1.guffin, if1.halfDollar_out, if1.quarter_out, if1.coin_reject};
        o.cr   = int'(if1.credit);
      end
      default: begin
        o.kind = {if2.guffin, if2.halfDollar_out, if2.quarter_out, if2.coin_reject};
        o.cr   = int'(if2.credit);
      end
    endcase
    return o;
  endfunction

  always @(negedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      ev_t o, e;
      o = observe(i);
      if (o.kind != 4'b0000) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse dut%0d actual kind %b credit %0d required none",
                   i, o.kind, o.cr);
        end else begin
          e = exp_q.pop_front();
          if (e.id != i || e.kind != o.kind || e.cr != o.cr) begin
            errors++;
            $display("FAIL pulse_event dut%0d actual kind %b credit %0d required dut%0d kind %b credit %0d",
                     i, o.kind, o.cr, e.id, e.kind, e.cr);
          end
        end
      end
    end
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    for (int i = 0; i < 3; i++) set_in(i, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PVC_CANCEL_EN
    if0.cancel = 1'b0; if1.cancel = 1'b0; if2.cancel = 1'b0;
`endif
    repeat (2) tick();
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    chk("reset_state0", int'(if0.state), 0);
    chk("reset_credit0", int'(if0.credit), 0);
    chk("reset_sold_out0", int'(if0.sold_out), 0);
    chk("reset_credit1", int'(if1.credit), 0);
    chk("reset_sold_out2", int'(if2.sold_out), 0);

    // Dollar on default price: vend then one quarter back.
    expect_ev(0, K_G, 4);
    expect_ev(0, K_Q, 1);
    drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("dollar_vend_state", int'(if0.state), 2);
    chk("dollar_vend_credit", int'(if0.credit), 4);
    tick();
    chk("dollar_change_state", int'(if0.state), 3);
    chk("dollar_change_credit", int'(if0.credit), 1);
    tick();
    chk("dollar_idle_state", int'(if0.state), 0);
    chk("dollar_idle_credit", int'(if0.credit), 0);

    // Half then dollar: credit 6, change as half-dollar then quarter.
    expect_ev(0, K_G, 6);
    expect_ev(0, K_H, 3);
    expect_ev(0, K_Q, 1);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("half_collect_state", int'(if0.state), 1);
    chk("half_collect_credit", int'(if0.credit), 2);
    drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("six_vend_credit", int'(if0.credit), 6);
    repeat (3) tick();
    chk("six_idle_state", int'(if0.state), 0);
    chk("six_idle_credit", int'(if0.credit), 0);

    // Coin offered during VEND is bounced while change is paid.
    expect_ev(0, K_G, 4);
    expect_ev(0, K_Q | K_R, 1);
    drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("vend_coin_credit", int'(if0.credit), 1);
    tick();
    chk("vend_coin_idle_credit", int'(if0.credit), 0);

    // Two coins at once are rejected with no credit.
    expect_ev(0, K_R, 0);
    drive(0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("multi_coin_credit", int'(if0.credit), 0);
    chk("multi_coin_state", int'(if0.state), 0);
    tick();

    // Reset in CHANGE with 3 owed discards it silently.
    expect_ev(0, K_G, 6);
    expect_ev(0, K_H, 3);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("pre_reset_credit", int'(if0.credit), 3);
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    chk("mid_reset_state", int'(if0.state), 0);
    chk("mid_reset_credit", int'(if0.credit), 0);
    repeat (3) tick();

`ifdef PVC_CANCEL_EN
    expect_ev(0, K_H, 2);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
    if0.cancel = 1'b1;
    tick();
    if0.cancel = 1'b0;
    chk("cancel_state", int'(if0.state), 3);
    chk("cancel_credit", int'(if0.credit), 2);
    tick();
    chk("cancel_idle_state", int'(if0.state), 0);
    chk("cancel_idle_credit", int'(if0.credit), 0);
    tick();
`endif

    // Price 8, ceiling 9: overflow reject, then exact-ceiling accept.
    expect_ev(1, K_R, 6);
    drive(1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("p8_credit6", int'(if1.credit), 6);
    chk("p8_collect", int'(if1.state), 1);
    drive(1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("p8_overflow_credit", int'(if1.credit), 6);
    chk("p8_overflow_state", int'(if1.state), 1);
    expect_ev(1, K_G, 9);
    expect_ev(1, K_Q, 1);
    drive(1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("p8_credit7", int'(if1.credit), 7);
    drive(1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("p8_ceiling_vend", int'(if1.state), 2);
    chk("p8_ceiling_credit", int'(if1.credit), 9);
    repeat (2) tick();
    chk("p8_idle_credit", int'(if1.credit), 0);

    // Single-item stock: sell out, reject, restock.
    expect_ev(2, K_G, 4);
    expect_ev(2, K_Q, 1);
    drive(2, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) tick();
    chk("s1_sold_out", int'(if2.sold_out), 1);
    chk("s1_idle", int'(if2.state), 0);
    expect_ev(2, K_R, 0);
    drive(2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s1_reject_credit", int'(if2.credit), 0);
    chk("s1_reject_state", int'(if2.state), 0);
    drive(2, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("s1_restock", int'(if2.sold_out), 0);
    drive(2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s1_after_restock_state", int'(if2.state), 1);
    chk("s1_after_restock_credit", int'(if2.credit), 1);

    repeat (3) tick();
    chk("pending_events", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
